// File: rtl/rr_arbiter_4_if.sv
// Request/grant bundle between the four agents and the round-robin arbiter.
// master: the agent side (drives requests); slave: the arbiter side.
interface rr_arbiter_4_if;
  logic       req_0;
  logic       req_1;
  logic       req_2;
  logic       req_3;
  logic       gnt_0;
  logic       gnt_1;
  logic       gnt_2;
  logic       gnt_3;
  logic [1:0] gnt_id;
  logic       busy;
  logic       timeout;

  modport master (
    output req_0, req_1, req_2, req_3,
    input  gnt_0, gnt_1, gnt_2, gnt_3, gnt_id, busy, timeout
  );

  modport slave (
    input  req_0, req_1, req_2, req_3,
    output gnt_0, gnt_1, gnt_2, gnt_3, gnt_id, busy, timeout
  );
endinterface

// File: rtl/rr_arbiter_4.sv
// Four-requester round-robin arbiter with bounded tenure.
// One owner at a time, a one-cycle all-low gap between owners, and a forced
// release plus one-cycle timeout pulse when a tenure reaches MAX_HOLD cycles.
// Every output comes straight from a flop; req only feeds next-state logic.
// MAX_HOLD must lie in 1..(2**CNT_W - 1) so the tenure counter can reach it.
module rr_arbiter_4 #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4
) (
  input  logic          clock,
  input  logic          reset,
  rr_arbiter_4_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_LIMIT = CNT_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  state_t           state, state_nxt;
  logic [3:0]       req;
  logic [3:0]       gnt, gnt_nxt;
  logic [1:0]       gnt_id, gnt_id_nxt;
  logic [1:0]       last, last_nxt;
  logic             busy, busy_nxt;
  logic             timeout, timeout_nxt;
  logic [CNT_W-1:0] hold_cnt, hold_cnt_nxt;

  logic             win_vld;
  logic [1:0]       win_id;
  logic [1:0]       cand;
  logic             owner_req;

  assign req = {bus.req_3, bus.req_2, bus.req_1, bus.req_0};

  // Round-robin pick: scan last+1, last+2, last+3, last; first requester wins.
  // The previous owner comes last, so it only wins again when alone.
  always_comb begin
    win_vld = 1'b0;
    win_id  = 2'd0;
    cand    = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      cand = last + 2'(k);
      if (!win_vld && req[cand]) begin
        win_vld = 1'b1;
        win_id  = cand;
      end
    end
  end

  // The current owner's own request decides whether its tenure continues.
  assign owner_req = req[gnt_id];

  // Next-state and next-output logic; holding everything is the default.
  always_comb begin
    state_nxt    = state;
    gnt_nxt      = gnt;
    gnt_id_nxt   = gnt_id;
    busy_nxt     = busy;
    timeout_nxt  = 1'b0;
    hold_cnt_nxt = hold_cnt;
    last_nxt     = last;

    unique case (state)
      // IDLE and RELEASE arbitrate identically; RELEASE just never lingers.
      IDLE, RELEASE: begin
        gnt_nxt      = 4'b0000;
        gnt_id_nxt   = 2'd0;
        busy_nxt     = 1'b0;
        hold_cnt_nxt = '0;
        state_nxt    = IDLE;
        if (win_vld) begin
          gnt_nxt         = 4'b0000;
          gnt_nxt[win_id] = 1'b1;
          gnt_id_nxt      = win_id;
          busy_nxt        = 1'b1;
          hold_cnt_nxt    = CNT_ONE;
          state_nxt       = GRANT;
        end
      end

      // Other agents are not looked at here: no preemption mid-tenure.
      // A voluntary drop wins over the limit, so no timeout in that case.
      GRANT: begin
        if (!owner_req || (hold_cnt == HOLD_LIMIT)) begin
          gnt_nxt      = 4'b0000;
          gnt_id_nxt   = 2'd0;
          busy_nxt     = 1'b0;
          hold_cnt_nxt = '0;
          last_nxt     = gnt_id;
          timeout_nxt  = owner_req;
          state_nxt    = RELEASE;
        end else begin
          hold_cnt_nxt = hold_cnt + CNT_ONE;
        end
      end

      default: begin
        gnt_nxt      = 4'b0000;
        gnt_id_nxt   = 2'd0;
        busy_nxt     = 1'b0;
        hold_cnt_nxt = '0;
        state_nxt    = IDLE;
      end
    endcase
  end

  // State and output registers; reset drops grants at once and hands
  // top priority back to agent 0 by parking last at 3.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      gnt      <= 4'b0000;
      gnt_id   <= 2'd0;
      busy     <= 1'b0;
      timeout  <= 1'b0;
      hold_cnt <= '0;
      last     <= 2'd3;
    end else begin
      state    <= state_nxt;
      gnt      <= gnt_nxt;
      gnt_id   <= gnt_id_nxt;
      busy     <= busy_nxt;
      timeout  <= timeout_nxt;
      hold_cnt <= hold_cnt_nxt;
      last     <= last_nxt;
    end
  end

  assign bus.gnt_0   = gnt[0];
  assign bus.gnt_1   = gnt[1];
  assign bus.gnt_2   = gnt[2];
  assign bus.gnt_3   = gnt[3];
  assign bus.gnt_id  = gnt_id;
  assign bus.busy    = busy;
  assign bus.timeout = timeout;

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Bench for rr_arbiter_4: directed scenarios followed by random request
// traffic, scored against a cycle-level ownership model.
module tb_rr_arbiter_4;
  localparam int MAX_HOLD = 8;
  localparam int CNT_W    = 4;

  typedef struct packed {
    logic [3:0] gnt;
    logic [1:0] id;
    logic       busy;
    logic       to;
  } obs_t;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] req_drv = 4'b0000;

  int checks = 0;
  int errors = 0;

  obs_t exp_q[$];

  rr_arbiter_4_if bus();

  assign bus.req_0 = req_drv[0];
  assign bus.req_1 = req_drv[1];
  assign bus.req_2 = req_drv[2];
  assign bus.req_3 = req_drv[3];

  rr_arbiter_4 #(.MAX_HOLD(MAX_HOLD), .CNT_W(CNT_W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  function automatic obs_t observe();
    obs_t o;
    o.gnt  = {bus.gnt_3, bus.gnt_2, bus.gnt_1, bus.gnt_0};
    o.id   = bus.gnt_id;
    o.busy = bus.busy;
    o.to   = bus.timeout;
    return o;
  endfunction

  task automatic chk(input string name, input obs_t act, input obs_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got gnt=%b id=%0d busy=%b to=%b want gnt=%b id=%0d busy=%b to=%b",
               name, $time, act.gnt, act.id, act.busy, act.to,
               exp.gnt, exp.id, exp.busy, exp.to);
    end
  endtask

  // Reference model: the resource is either owned (owner, tenure count) or
  // free; a free resource is offered to the rotating scan at every edge.
  // Releasing always leaves one edge with no owner, which is the gap.
  initial begin : model
    int   owner;
    int   tenure;
    int   last;
    logic to;
    obs_t e;
    owner = -1; tenure = 0; last = 3; to = 1'b0;
    forever begin
      @(posedge clock);
      if (reset) begin
        owner = -1; tenure = 0; last = 3;
        exp_q.delete();
      end else begin
        to = 1'b0;
        if (owner < 0) begin
          for (int k = 1; k <= 4; k++) begin
            if (owner < 0 && req_drv[(last + k) % 4]) begin
              owner  = (last + k) % 4;
              tenure = 1;
            end
          end
        end else if (!req_drv[owner]) begin
          last  = owner;
          owner = -1;
        end else if (tenure == MAX_HOLD) begin
          last  = owner;
          owner = -1;
          to    = 1'b1;
        end else begin
          tenure++;
        end
        e = '0;
        if (owner >= 0) begin
          e.gnt[owner] = 1'b1;
          e.id         = 2'(owner);
          e.busy       = 1'b1;
        end
        e.to = to;
        exp_q.push_back(e);
      end
    end
  end

  // Monitor: on each falling edge compare the DUT against the oldest
  // expectation, and independently bound the length of any grant run.
  initial begin : monitor
    obs_t act;
    obs_t e;
    obs_t zero;
    int   run;
    zero = '0;
    run  = 0;
    forever begin
      @(negedge clock);
      act = observe();
      if (reset) begin
        run = 0;
        chk("reset_state", act, zero);
      end else if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("cycle", act, e);
        if (act.busy) run++;
        else          run = 0;
        checks++;
        if (run > MAX_HOLD) begin
          errors++;
          $display("FAIL tenure_bound t=%0t got run=%0d want <=%0d", $time, run, MAX_HOLD);
        end
      end
    end
  end

  // Drive r for n consecutive cycles, changing just after the falling edge.
  task automatic step(input logic [3:0] r, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      #1 req_drv = r;
    end
  endtask

  task automatic pulse_reset();
    @(negedge clock);
    #1 reset = 1'b1;
    req_drv = 4'b0000;
    @(negedge clock);
    #1 reset = 1'b0;
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog t=%0t simulation did not end", $time);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    obs_t act;
    obs_t exp;
    logic [3:0] r;

    repeat (2) @(negedge clock);
    #1 reset = 1'b0;

    // Single requester: grant one edge after sampling, release one after drop.
    step(4'b0001, 4);
    step(4'b0000, 3);

    // Everyone requesting from reset: 0,1,2,3,0 with full tenures.
    pulse_reset();
    step(4'b1111, 46);
    step(4'b0000, 3);

    // Agent 1 last owner, then 1 and 2 together: 2 goes first.
    step(4'b0010, 2);
    step(4'b0000, 3);
    step(4'b0110, 24);
    step(4'b0000, 3);

    // Sole requester past the limit gets cut, then re-granted.
    step(4'b1000, 24);
    step(4'b0000, 3);

    // Drop exactly on the edge where the tenure limit is reached.
    step(4'b0001, MAX_HOLD);
    step(4'b0000, 3);

    // Reset mid-tenure drops the grant without waiting for a clock edge.
    pulse_reset();
    step(4'b0100, 3);
    exp = '0;
    exp.gnt[2] = 1'b1; exp.id = 2'd2; exp.busy = 1'b1;
    act = observe();
    chk("pre_reset_gnt2", act, exp);
    reset = 1'b1;
    #1;
    act = observe();
    chk("async_reset_clear", act, '0);
    req_drv = 4'b0101;
    @(negedge clock);
    #1 reset = 1'b0;
    step(4'b0101, 12);
    step(4'b0000, 3);

    // Random traffic: each request bit flips occasionally so tenures vary.
    r = 4'b0000;
    for (int i = 0; i < 2000; i++) begin
      for (int b = 0; b < 4; b++)
        if ($urandom_range(0, 7) == 0) r[b] = ~r[b];
      step(r, 1);
      if ($urandom_range(0, 499) == 0) pulse_reset();
    end
    step(4'b0000, 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
